// File: rtl/cg_edge_filter.sv
// cg_edge_filter: synchronizes and debounces a glitchy gate-network level, emitting
// edge strobes and a wrapping count of accepted rises with a sticky overflow flag.
module cg_edge_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_in,
    input  logic             clr,
    output logic             w_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic             ovf
);
    typedef enum logic [1:0] {LOW, PEND_HIGH, HIGH, PEND_LOW} state_t;
    localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       s1, s, rise_nx, fall_nx;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOW:       if (s) begin state_nx = PEND_HIGH; cnt_nx = 4'd1; end
            PEND_HIGH: if (!s) begin state_nx = LOW; cnt_nx = 4'd0; end
                       else if (cnt == LAST) begin state_nx = HIGH; cnt_nx = 4'd0; end
                       else cnt_nx = cnt + 4'd1;
            HIGH:      if (!s) begin state_nx = PEND_LOW; cnt_nx = 4'd1; end
            default:   if (s) begin state_nx = HIGH; cnt_nx = 4'd0; end
                       else if (cnt == LAST) begin state_nx = LOW; cnt_nx = 4'd0; end
                       else cnt_nx = cnt + 4'd1;
        endcase
        rise_nx = state == PEND_HIGH && state_nx == HIGH;
        fall_nx = state == PEND_LOW && state_nx == LOW;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s          <= 1'b0;
            state      <= LOW;
            cnt        <= 4'd0;
            w_filt     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            rise_count <= '0;
            ovf        <= 1'b0;
        end else begin
            s1         <= w_in;
            s          <= s1;
            state      <= state_nx;
            cnt        <= cnt_nx;
            w_filt     <= state_nx == HIGH || state_nx == PEND_LOW;
            rise_pulse <= rise_nx;
            fall_pulse <= fall_nx;
            // a clear coinciding with a rise still counts that rise
            if (clr) begin
                rise_count <= {{(CNT_W-1){1'b0}}, rise_pulse};
                ovf        <= 1'b0;
            end else if (rise_pulse) begin
                rise_count <= rise_count + 1'b1;
                if (&rise_count) ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cg_edge_filter.sv
// tb_cg_edge_filter: directed stimulus against a run-length debounce model, checked
// every cycle, plus literal timing checks on two instances (CNT_W 8 and 3).
module tb_cg_edge_filter;
    localparam int SC = 4;
    logic clk = 1'b0, rst = 1'b1, w_in = 1'b0, clr = 1'b0;
    logic wf, rp, fp, ov, wf3, rp3, fp3, ov3;
    logic [7:0] rc;
    logic [2:0] rc3;
    int n_cmp = 0, n_fail = 0, pulses;

    always #5 clk = ~clk;

    cg_edge_filter #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .w_in(w_in), .clr(clr), .w_filt(wf), .rise_pulse(rp),
        .fall_pulse(fp), .rise_count(rc), .ovf(ov));
    cg_edge_filter #(.STABLE_CYCLES(SC), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .w_in(w_in), .clr(clr), .w_filt(wf3), .rise_pulse(rp3),
        .fall_pulse(fp3), .rise_count(rc3), .ovf(ov3));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: the filtered level flips once SC consecutive synchronized samples disagree with it
    bit m1, m2, m_filt, m_rp, m_fp, m_ov, m_ov3;
    int run, m_rc, m_rc3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = 0; m2 = 0; m_filt = 0; m_rp = 0; m_fp = 0; run = 0;
            m_rc = 0; m_rc3 = 0; m_ov = 0; m_ov3 = 0;
        end else begin
            if (clr) begin
                m_rc = m_rp; m_rc3 = m_rp; m_ov = 0; m_ov3 = 0;
            end else if (m_rp) begin
                m_rc = (m_rc + 1) % 256; if (m_rc == 0) m_ov = 1;
                m_rc3 = (m_rc3 + 1) % 8; if (m_rc3 == 0) m_ov3 = 1;
            end
            m_rp = 0; m_fp = 0;
            run = (m2 != m_filt) ? run + 1 : 0;
            if (run == SC) begin
                m_filt = !m_filt; m_rp = m_filt; m_fp = !m_filt; run = 0;
            end
            m2 = m1; m1 = w_in;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("w_filt", wf, m_filt);
        chk("rise_pulse", rp, m_rp);
        chk("fall_pulse", fp, m_fp);
        chk("rise_count", rc, m_rc);
        chk("ovf", ov, m_ov);
        chk("w_filt3", wf3, m_filt);
        chk("rise_count3", rc3, m_rc3);
        chk("ovf3", ov3, m_ov3);
        chk("no_both_pulses", rp & fp, 0);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_w_filt", wf, 0);
        chk("reset_count", rc, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        // setup: rise appears after the 6th edge
        w_in = 1;
        repeat (5) @(posedge clk);
        #1 chk("setup_before_e5", wf, 0);
        @(posedge clk);
        #1 chk("setup_w_filt_e5", wf, 1);
        chk("setup_rise_e5", rp, 1);
        chk("setup_fall_e5", fp, 0);
        @(posedge clk);
        #1 chk("setup_count", rc, 1);
        chk("setup_pulse_gone", rp, 0);
        @(negedge clk) w_in = 0;
        repeat (10) @(negedge clk);
        // glitch: 13 ns high pulse
        @(posedge clk);
        #2 w_in = 1;
        #13 w_in = 0;
        repeat (10) @(negedge clk);
        chk("glitch_w_filt", wf, 0);
        chk("glitch_count", rc, 1);
        // bounce 1,0,1 then hold
        w_in = 1;
        #20 w_in = 0;
        #20 w_in = 1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (rp) pulses++;
        end
        chk("bounce_pulses", pulses, 1);
        chk("bounce_count", rc, 2);
        // wrap on the 3-bit instance
        clr = 1;
        @(negedge clk) clr = 0;
        w_in = 0;
        repeat (10) @(negedge clk);
        repeat (8) begin
            w_in = 1;
            repeat (10) @(negedge clk);
            w_in = 0;
            repeat (10) @(negedge clk);
        end
        chk("wrap_count3", rc3, 0);
        chk("wrap_ovf3", ov3, 1);
        chk("wrap_count8", rc, 8);
        // clr coincident with rise_pulse
        w_in = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("clr_rise_pulse", rp, 1);
        clr = 1;
        @(negedge clk) clr = 0;
        chk("clr_rise_count3", rc3, 1);
        chk("clr_rise_ovf3", ov3, 0);
        chk("clr_rise_count8", rc, 1);
        w_in = 0;
        repeat (10) @(negedge clk);
        // short async reset while pending high
        w_in = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #2 chk("rst_w_filt", wf, 0);
        chk("rst_count", rc, 0);
        chk("rst_rise", rp, 0);
        #1 rst = 0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rp) pulses++;
        end
        chk("rst_then_one_rise", pulses, 1);
        chk("rst_then_count", rc, 1);
        // standalone clr
        clr = 1;
        @(negedge clk) clr = 0;
        chk("clr_count", rc, 0);
        chk("clr_ovf", ov, 0);
        chk("clr_keeps_w_filt", wf, 1);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
